// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one RAM port between the icache and dcache miss paths.
// The dcache normally wins; a starvation counter guarantees the icache a turn.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_starveCnt;
  logic [3:0] w_nextStarve;
  logic       w_iReq;
  logic       w_dReq;
  logic       w_dWins;

  assign w_iReq  = iREN;
  assign w_dReq  = dREN | dWEN;
  assign w_dWins = w_dReq & (~w_iReq | (r_starveCnt < LIMIT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_starveCnt <= 4'd0;
    end else begin
      r_state     <= w_nextState;
      r_starveCnt <= w_nextStarve;
    end
  end

  // Strobes follow the live request so an abort drops them in the same cycle;
  // reset overrides everything so no wait-low pulse can escape mid-access.
  always_comb begin
    w_nextState  = r_state;
    w_nextStarve = r_starveCnt;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = 32'd0;
    dload        = 32'd0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'd0;
    ramstore     = 32'd0;

    case (r_state)
      IDLE: begin
        if (w_dWins) begin
          w_nextState = DGNT;
          if (w_iReq && (r_starveCnt < LIMIT)) begin
            w_nextStarve = r_starveCnt + 4'd1;
          end
        end else if (w_iReq) begin
          w_nextState  = IGNT;
          w_nextStarve = 4'd0;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        if (!w_iReq) begin
          w_nextState = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait       = 1'b0;
          w_nextState = IDLE;
        end
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        if (!w_dReq) begin
          w_nextState = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait       = 1'b0;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (RST) begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = 32'd0;
      dload    = 32'd0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against an ownership/turn-counting model.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dstore = 32'd0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = 32'd0;
  logic [1:0]  ramstate = 2'd0;

  int nChecks = 0;
  int nFails  = 0;

  // Model: who currently owns the RAM (0 nobody, 1 icache, 2 dcache) and how many
  // dcache turns the waiting icache has sat through.
  int owner  = 0;
  int starve = 0;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] ds, input logic [1:0] rs,
                               input logic [31:0] rl);
    @(posedge CLK);
    #1;
    RST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    @(negedge CLK);
    #1;
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      owner  <= 0;
      starve <= 0;
    end else if (owner == 0) begin
      if ((dREN || dWEN) && (!iREN || starve < STARVE_LIMIT)) begin
        owner <= 2;
        if (iREN) starve <= (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
      end else if (iREN) begin
        owner  <= 1;
        starve <= 0;
      end
    end else if (owner == 1) begin
      if (!iREN || ramstate == 2'd2) owner <= 0;
    end else begin
      if (!(dREN || dWEN) || ramstate == 2'd2) owner <= 0;
    end
  end

  always @(negedge CLK) begin : compareProc
    logic        eIwait, eDwait, eRen, eWen;
    logic [31:0] eAddr, eStore, eIload, eDload;
    eIwait = 1'b1; eDwait = 1'b1; eRen = 1'b0; eWen = 1'b0;
    eAddr = 32'd0; eStore = 32'd0; eIload = 32'd0; eDload = 32'd0;
    if (!RST && owner == 1) begin
      eRen   = iREN;
      eAddr  = iaddr;
      eIload = ramload;
      eIwait = !(iREN && ramstate == 2'd2);
    end else if (!RST && owner == 2) begin
      eWen   = dWEN;
      eRen   = dREN && !dWEN;
      eAddr  = daddr;
      eStore = dstore;
      eDload = ramload;
      eDwait = !((dREN || dWEN) && ramstate == 2'd2);
    end
    checkOutput("model iwait",    {31'd0, iwait},  {31'd0, eIwait});
    checkOutput("model dwait",    {31'd0, dwait},  {31'd0, eDwait});
    checkOutput("model ramREN",   {31'd0, ramREN}, {31'd0, eRen});
    checkOutput("model ramWEN",   {31'd0, ramWEN}, {31'd0, eWen});
    checkOutput("model ramaddr",  ramaddr,  eAddr);
    checkOutput("model ramstore", ramstore, eStore);
    checkOutput("model iload",    iload,    eIload);
    checkOutput("model dload",    dload,    eDload);
  end

  initial begin
    logic [9:0]  grants;
    int          nGrants;
    logic        iActive, dActive, iDone, dDone, wr, rd, rstR;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    int          pick;

    $display("[TB] directed: reset with requests pending");
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, 1, 32'h0000_0AA0, 1, 0, 32'h0000_0300, 32'd0, 2'd0, 32'd0);
      checkOutput("reset iwait",   {31'd0, iwait},  32'd1);
      checkOutput("reset dwait",   {31'd0, dwait},  32'd1);
      checkOutput("reset ramREN",  {31'd0, ramREN}, 32'd0);
      checkOutput("reset ramWEN",  {31'd0, ramWEN}, 32'd0);
      checkOutput("reset ramaddr", ramaddr, 32'd0);
    end
    applyStimulus(0, 1, 32'h0000_0AA0, 1, 0, 32'h0000_0300, 32'd0, 2'd0, 32'd0);
    checkOutput("post-reset idle ramREN", {31'd0, ramREN}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0AA0, 1, 0, 32'h0000_0300, 32'd0, 2'd0, 32'd0);
    checkOutput("post-reset grant ramREN", {31'd0, ramREN}, 32'd1);
    checkOutput("post-reset grant ramaddr", ramaddr, 32'h0000_0300);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);
    checkOutput("abort ramREN", {31'd0, ramREN}, 32'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);

    $display("[TB] directed: single icache read");
    applyStimulus(0, 1, 32'h0000_0100, 0, 0, 32'd0, 32'd0, 2'd1, 32'd0);
    checkOutput("iread idle ramREN", {31'd0, ramREN}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 1, 32'h0000_0100, 0, 0, 32'd0, 32'd0,
                    (c == 2) ? 2'd2 : 2'd1, (c == 2) ? 32'hDEAD_BEEF : 32'h1111_2222);
      checkOutput("iread ramREN",  {31'd0, ramREN}, 32'd1);
      checkOutput("iread ramaddr", ramaddr, 32'h0000_0100);
      checkOutput("iread iwait",   {31'd0, iwait}, (c == 2) ? 32'd0 : 32'd1);
    end
    checkOutput("iread iload", iload, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);
    checkOutput("iread after ramREN", {31'd0, ramREN}, 32'd0);

    $display("[TB] directed: dcache write priority");
    applyStimulus(0, 1, 32'h0000_0180, 0, 1, 32'h0000_0200, 32'h0000_1234, 2'd2, 32'd0);
    checkOutput("prio idle ramWEN", {31'd0, ramWEN}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0180, 0, 1, 32'h0000_0200, 32'h0000_1234, 2'd2, 32'd0);
    checkOutput("prio ramWEN",   {31'd0, ramWEN}, 32'd1);
    checkOutput("prio ramstore", ramstore, 32'h0000_1234);
    checkOutput("prio ramaddr",  ramaddr, 32'h0000_0200);
    checkOutput("prio dwait",    {31'd0, dwait}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0180, 0, 0, 32'd0, 32'd0, 2'd2, 32'd0);
    checkOutput("prio gap ramREN", {31'd0, ramREN}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0180, 0, 0, 32'd0, 32'd0, 2'd2, 32'h0BAD_F00D);
    checkOutput("prio igrant ramaddr", ramaddr, 32'h0000_0180);
    checkOutput("prio igrant iwait", {31'd0, iwait}, 32'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);

    $display("[TB] directed: starvation guard");
    grants  = '0;
    nGrants = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, 1, 32'h0000_0400, 1, 0, 32'h0000_0500, 32'd0, 2'd2, $urandom);
      if (!dwait) begin grants = {grants[8:0], 1'b1}; nGrants++; end
      if (!iwait) begin grants = {grants[8:0], 1'b0}; nGrants++; end
    end
    checkOutput("starve grant count", nGrants, 32'd10);
    checkOutput("starve grant order", {22'd0, grants}, {22'd0, 10'b1111011110});
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);

    $display("[TB] directed: ERROR hold then abort");
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h0000_0700, 32'd0, 2'd3, 32'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 32'd0, 1, 0, 32'h0000_0700, 32'd0, 2'd3, 32'd0);
      checkOutput("error dwait",  {31'd0, dwait},  32'd1);
      checkOutput("error ramREN", {31'd0, ramREN}, 32'd1);
    end
    applyStimulus(0, 0, 32'd0, 0, 0, 32'h0000_0700, 32'd0, 2'd3, 32'd0);
    checkOutput("abort dwait",  {31'd0, dwait},  32'd1);
    checkOutput("abort ramREN", {31'd0, ramREN}, 32'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd2, 32'd0);
    checkOutput("abort idle dwait", {31'd0, dwait}, 32'd1);

    $display("[TB] directed: reset mid-access");
    applyStimulus(0, 1, 32'h0000_0600, 0, 0, 32'd0, 32'd0, 2'd1, 32'd0);
    applyStimulus(0, 1, 32'h0000_0600, 0, 0, 32'd0, 32'd0, 2'd1, 32'd0);
    checkOutput("midrst grant ramREN", {31'd0, ramREN}, 32'd1);
    applyStimulus(1, 1, 32'h0000_0600, 0, 0, 32'd0, 32'd0, 2'd2, 32'd0);
    checkOutput("midrst ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("midrst iwait",  {31'd0, iwait},  32'd1);
    applyStimulus(0, 1, 32'h0000_0600, 0, 0, 32'd0, 32'd0, 2'd2, 32'd0);
    checkOutput("midrst idle ramREN", {31'd0, ramREN}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0600, 0, 0, 32'd0, 32'd0, 2'd2, 32'd0);
    checkOutput("midrst regrant iwait", {31'd0, iwait}, 32'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);

    $display("[TB] random traffic");
    iActive = 0; dActive = 0; iDone = 0; dDone = 0;
    wr = 0; rd = 0; ia = 0; da = 0; ds = 0;
    for (int c = 0; c < 3000; c++) begin
      if (iActive && (iDone || $urandom_range(0, 19) == 0)) iActive = 0;
      else if (!iActive && $urandom_range(0, 2) == 0) begin iActive = 1; ia = $urandom; end
      if (dActive && (dDone || $urandom_range(0, 19) == 0)) dActive = 0;
      else if (!dActive && $urandom_range(0, 2) == 0) begin
        dActive = 1; da = $urandom; ds = $urandom;
        pick = $urandom_range(0, 2);
        wr = (pick != 0); rd = (pick != 1);
      end
      pick = $urandom_range(0, 7);
      rs   = (pick < 2) ? 2'd0 : (pick < 4) ? 2'd1 : (pick < 7) ? 2'd2 : 2'd3;
      rstR = ($urandom_range(0, 149) == 0);
      applyStimulus(rstR, iActive, ia, dActive & rd, dActive & wr, da, ds, rs, $urandom);
      iDone = !iwait;
      dDone = !dwait;
    end

    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
